// File: rtl/shifter_pkg.sv
// Shared constants for the I/O-port shift units.
// Mode register layout used by shift_unit_n.
package shifter_pkg;

  localparam int MODE_W    = 3;
  localparam int MODE_DIR  = 0;
  localparam int MODE_REV  = 1;
  localparam int MODE_AINC = 2;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/shift_unit_n_bit_reverse.sv
// Bit-order reversal of a W-bit word.
// Pure wiring; used for the reversed readout path.
module bit_reverse #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign o_data[i] = i_data[W-1-i];
  end

endmodule

// File: rtl/shift_unit_n.sv
// Parametrised port-mapped shift unit: word window, offset,
// direction / reverse / auto-increment modes and fill flag.
module shift_unit_n
  import shifter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WORDS  = 2,
  parameter int PIPE   = 0,
  localparam int OFF_W = $clog2((WORDS-1)*DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_data,
  input  logic              i_wr_offset,
  input  logic              i_wr_mode,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);

  localparam int WIN_W = WORDS * DATA_W;
  localparam int SPAN  = (WORDS - 1) * DATA_W;
  localparam int CNT_W = $clog2(WORDS + 1);

  if (WORDS < 2) begin : g_chk_words
    $error("shift_unit_n: WORDS must be at least 2");
  end
  if (!is_pow2(SPAN)) begin : g_chk_span
    $error("shift_unit_n: (WORDS-1)*DATA_W must be a power of two");
  end
  if (OFF_W > DATA_W || DATA_W < MODE_W) begin : g_chk_bus
    $error("shift_unit_n: data bus too narrow for offset/mode");
  end

  logic [WIN_W-1:0]  r_win;
  logic [OFF_W-1:0]  r_off;
  logic [MODE_W-1:0] r_mode;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_full;
  logic [WIN_W-1:0]  w_shl;
  logic [WIN_W-1:0]  w_shr;
  logic [DATA_W-1:0] w_res;
  logic [DATA_W-1:0] w_rev;
  logic [DATA_W-1:0] w_out;

  assign w_full = (r_cnt == CNT_W'(WORDS));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win  <= '0;
      r_off  <= '0;
      r_mode <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_wr_data) begin
        r_win <= {i_data, r_win[WIN_W-1:DATA_W]};
      end
      if (i_wr_data && !w_full) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // An explicit offset write beats a same-cycle auto-increment.
      if (i_wr_offset) begin
        r_off <= i_data[OFF_W-1:0];
      end else if (i_rd && r_mode[MODE_AINC]) begin
        r_off <= r_off + 1'b1;
      end
      if (i_wr_mode) begin
        r_mode <= i_data[MODE_W-1:0];
      end
    end
  end

  assign w_shl = r_win << r_off;
  assign w_shr = r_win >> r_off;
  assign w_res = r_mode[MODE_DIR] ? w_shr[DATA_W-1:0]
                                  : w_shl[WIN_W-1 -: DATA_W];

  bit_reverse #(
    .W (DATA_W)
  ) u_rev (
    .i_data (w_res),
    .o_data (w_rev)
  );

  assign w_out = r_mode[MODE_REV] ? w_rev : w_res;

  if (PIPE != 0) begin : g_pipe
    logic [DATA_W-1:0] r_out;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_out <= '0;
      end else begin
        r_out <= w_out;
      end
    end
    assign o_data = r_out;
  end else begin : g_comb
    assign o_data = w_out;
  end

  assign o_full = w_full;

endmodule
